// File: rtl/fire9_ofm_collector.sv
// Captures one DSP_NO-wide output-feature-map vector per pixel and drains it, one channel per cycle,
// into a channel-major layer RAM at ram[ch*WOUT^2 + pix]; ram_feedback pulses once the layer is complete.
module fire9_ofm_collector #(
  parameter int DSP_NO = 368,
  parameter int WIDTH  = 16,
  parameter int WOUT   = 8,
  parameter int DEPTH  = DSP_NO * WOUT * WOUT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             collect_en,
  input  logic             sample,
  input  logic [WIDTH-1:0] ofm [DSP_NO],
  output logic             ram_feedback,
  output logic             busy,
  output logic             overflow,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PIX_N = WOUT * WOUT;
  localparam int CW    = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PW    = $clog2(PIX_N + 1);

  localparam logic [CW-1:0] CH_LAST   = CW'(DSP_NO - 1);
  localparam logic [PW-1:0] PIX_END   = PW'(PIX_N);
  localparam logic [AW-1:0] STRIDE    = AW'(PIX_N);
  localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic [PW-1:0]    pix_inc;
  logic [AW-1:0]    base_q, base_d;
  logic             ram_feedback_q, ram_feedback_d;
  logic             overflow_q, overflow_d;
  logic             rd_ok_q, rd_ok_d;
  logic [WIDTH-1:0] shadow_q [DSP_NO];
  logic [WIDTH-1:0] shadow_d [DSP_NO];

  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word_q;

  // base_q tracks ch*WOUT^2 + pix by adding the stride once per drained channel.
  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    pix_d          = pix_q;
    base_d         = base_q;
    shadow_d       = shadow_q;
    overflow_d     = overflow_q;
    ram_feedback_d = 1'b0;
    ram_we         = 1'b0;
    pix_inc        = pix_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (sample && collect_en) begin
          shadow_d = ofm;
          ch_d     = '0;
          base_d   = AW'(pix_q);
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        ram_we = 1'b1;
        if (sample && collect_en) begin
          overflow_d = 1'b1;
        end
        if (ch_q == CH_LAST) begin
          ch_d  = '0;
          pix_d = pix_inc;
          if (pix_inc == PIX_END) begin
            state_d        = DONE;
            ram_feedback_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ch_d   = ch_q + 1'b1;
          base_d = base_q + STRIDE;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    rd_ok_d = rd_ok_q;
    if (rd_en) begin
      rd_ok_d = ({1'b0, rd_addr} < DEPTH_LIM);
    end
  end

  assign ram_waddr = base_q;
  assign ram_wdata = shadow_q[ch_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      ch_q           <= '0;
      pix_q          <= '0;
      base_q         <= '0;
      ram_feedback_q <= 1'b0;
      overflow_q     <= 1'b0;
      rd_ok_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      pix_q          <= pix_d;
      base_q         <= base_d;
      ram_feedback_q <= ram_feedback_d;
      overflow_q     <= overflow_d;
      rd_ok_q        <= rd_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  // Plain one-write/one-read RAM; rd_ok_q masks out-of-range reads and gives rd_data its reset value.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (rd_en) begin
      rd_word_q <= mem[rd_addr];
    end
  end

  assign rd_data      = rd_ok_q ? rd_word_q : '0;
  assign busy         = (state_q == DRAIN);
  assign overflow     = overflow_q;
  assign ram_feedback = ram_feedback_q;

endmodule

// File: tb/tb_fire9_ofm_collector.sv
// Bench for fire9_ofm_collector (DSP_NO=4, WOUT=2, DEPTH=16) plus a DEPTH=20 instance for out-of-range reads.
module tb_fire9_ofm_collector;

  localparam int DSP_NO = 4;
  localparam int WIDTH  = 16;
  localparam int WOUT   = 2;
  localparam int PIX    = WOUT * WOUT;

  logic             clk, rst, collect_en, sample;
  logic [WIDTH-1:0] ofm [DSP_NO];
  logic             ram_feedback, busy, overflow;
  logic             rd_en;
  logic [3:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             ram_feedback2, busy2, overflow2;
  logic             rd2_en;
  logic [4:0]       rd2_addr;
  logic [WIDTH-1:0] rd2_data;

  fire9_ofm_collector #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .collect_en(collect_en), .sample(sample), .ofm(ofm),
    .ram_feedback(ram_feedback), .busy(busy), .overflow(overflow),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  fire9_ofm_collector #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT), .DEPTH(20)) dut2 (
    .clk(clk), .rst(rst), .collect_en(collect_en), .sample(sample), .ofm(ofm),
    .ram_feedback(ram_feedback2), .busy(busy2), .overflow(overflow2),
    .rd_en(rd2_en), .rd_addr(rd2_addr), .rd_data(rd2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: layer memory, pending drain length, pixel count, sticky flags.
  logic [WIDTH-1:0] m_mem [16];
  bit               m_known [16];
  logic [WIDTH-1:0] m_vec [DSP_NO];
  int               m_left, m_pix;
  bit               m_done, m_ovf;
  bit               exp_busy, exp_fb, exp_ovf, exp_rd_known, exp_rd2_known;
  logic [WIDTH-1:0] exp_rd, exp_rd2;

  task automatic tick();
    bit fb;
    int c;
    fb = 1'b0;
    if (rd_en) begin
      exp_rd       = m_mem[rd_addr];
      exp_rd_known = m_known[rd_addr];
    end
    if (rd2_en) begin
      if (rd2_addr >= 5'd20) begin
        exp_rd2 = '0; exp_rd2_known = 1'b1;
      end else if (rd2_addr < 5'd16) begin
        exp_rd2 = m_mem[rd2_addr[3:0]]; exp_rd2_known = m_known[rd2_addr[3:0]];
      end else begin
        exp_rd2_known = 1'b0;
      end
    end
    if (m_left > 0) begin
      c = DSP_NO - m_left;
      m_mem[c * PIX + m_pix]   = m_vec[c];
      m_known[c * PIX + m_pix] = 1'b1;
      if (sample && collect_en) m_ovf = 1'b1;
      m_left--;
      if (m_left == 0) begin
        m_pix++;
        if (m_pix == PIX) begin
          m_done = 1'b1; fb = 1'b1;
        end
      end
    end else if (!m_done && sample && collect_en) begin
      m_vec  = ofm;
      m_left = DSP_NO;
    end
    @(posedge clk);
    #1;
    exp_busy = (m_left > 0);
    exp_fb   = fb;
    exp_ovf  = m_ovf;
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    m_left = 0; m_pix = 0; m_done = 1'b0; m_ovf = 1'b0;
    exp_busy = 1'b0; exp_fb = 1'b0; exp_ovf = 1'b0;
    exp_rd = '0; exp_rd_known = 1'b1; exp_rd2 = '0; exp_rd2_known = 1'b1;
    #2;
  endtask

  task automatic release_reset();
    sample = 1'b0; rd_en = 1'b0; rd2_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_ofm();
    foreach (ofm[i]) ofm[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; collect_en = 1'b0; sample = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd2_en = 1'b0; rd2_addr = '0;
    rand_ofm();
    foreach (m_known[i]) m_known[i] = 1'b0;
    #1;
    assert_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (ram_feedback !== 1'b0) begin errors++; $display("FAIL reset_feedback: got %b want 0", ram_feedback); end
    checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    release_reset();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_capture();
    logic [WIDTH-1:0] v [DSP_NO];
    collect_en = 1'b1; sample = 1'b1;
    for (int c = 0; c < DSP_NO; c++) ofm[c] = 16'(10 * (c + 1));
    tick();
    sample = 1'b0; rand_ofm();
    for (int i = 0; i < 6; i++) begin
      checks++; if (busy !== (i < 4)) begin errors++; $display("FAIL single_busy cyc%0d: got %b want %b", i, busy, (i < 4)); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL single_busy_model cyc%0d: got %b want %b", i, busy, exp_busy); end
      tick();
    end
    for (int c = 0; c < DSP_NO; c++) begin
      rd_en = 1'b1; rd_addr = 4'(4 * c);
      tick();
      checks++; if (rd_data !== 16'(10 * (c + 1))) begin errors++; $display("FAIL single_ram[%0d]: got %0d want %0d", 4 * c, rd_data, 10 * (c + 1)); end
    end
    rd_en = 1'b0;
    // A second capture must land at pixel 1.
    rand_ofm(); v = ofm; sample = 1'b1;
    tick();
    sample = 1'b0;
    repeat (5) tick();
    for (int c = 0; c < DSP_NO; c++) begin
      rd_en = 1'b1; rd_addr = 4'(4 * c + 1);
      tick();
      checks++; if (rd_data !== v[c]) begin errors++; $display("FAIL single_pix1_ram[%0d]: got %h want %h", 4 * c + 1, rd_data, v[c]); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] v1 [DSP_NO];
    logic [WIDTH-1:0] v3 [DSP_NO];
    assert_reset(); release_reset();
    collect_en = 1'b1; rand_ofm(); v1 = ofm; sample = 1'b1;
    tick();
    sample = 1'b0; rand_ofm();
    tick();
    sample = 1'b1;
    tick();
    sample = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (overflow !== exp_ovf || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky cyc%0d: got %b want 1", i, overflow); end
    end
    for (int c = 0; c < DSP_NO; c++) begin
      rd_en = 1'b1; rd_addr = 4'(4 * c);
      tick();
      checks++; if (rd_data !== v1[c]) begin errors++; $display("FAIL ovf_ram[%0d]: got %h want %h", 4 * c, rd_data, v1[c]); end
    end
    rd_en = 1'b0;
    rand_ofm(); v3 = ofm; sample = 1'b1;
    tick();
    sample = 1'b0;
    repeat (5) tick();
    for (int c = 0; c < DSP_NO; c++) begin
      rd_en = 1'b1; rd_addr = 4'(4 * c + 1);
      tick();
      checks++; if (rd_data !== v3[c]) begin errors++; $display("FAIL ovf_pix1_ram[%0d]: got %h want %h", 4 * c + 1, rd_data, v3[c]); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_overflow_last_write();
    assert_reset(); release_reset();
    collect_en = 1'b1; rand_ofm(); sample = 1'b1;
    tick();
    sample = 1'b0;
    repeat (3) tick();
    sample = 1'b1; rand_ofm();
    tick();
    sample = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL last_write_ovf: got %b want 1", overflow); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b0 || busy !== exp_busy) begin errors++; $display("FAIL last_write_no_capture cyc%0d: got %b want 0", i, busy); end
      tick();
    end
  endtask

  task automatic test_gating();
    assert_reset(); release_reset();
    collect_en = 1'b0; sample = 1'b1; ofm[0] = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_busy cyc%0d: got %b want 0", i, busy); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL gate_ovf cyc%0d: got %b want 0", i, overflow); end
    end
    sample = 1'b0; rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL gate_no_write: got %h want %h", rd_data, exp_rd); end
    collect_en = 1'b1; sample = 1'b1; rand_ofm();
    tick();
    collect_en = 1'b0;
    tick();
    sample = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL gate_drain_ovf: got %b want 0", overflow); end
    repeat (4) tick();
  endtask

  task automatic test_full_layer();
    int pulses;
    int want;
    assert_reset(); release_reset();
    collect_en = 1'b1; pulses = 0;
    for (int t = 0; t < 45; t++) begin
      if (t % 10 == 0 && t < 40) begin
        sample = 1'b1;
        for (int c = 0; c < DSP_NO; c++) ofm[c] = 16'(16 * c + t / 10);
      end else begin
        sample = 1'b0; rand_ofm();
      end
      tick();
      checks++; if (ram_feedback !== (t == 34)) begin errors++; $display("FAIL layer_fb t%0d: got %b want %b", t, ram_feedback, (t == 34)); end
      checks++; if (ram_feedback !== exp_fb || busy !== exp_busy) begin errors++; $display("FAIL layer_model t%0d: got fb%b busy%b want fb%b busy%b", t, ram_feedback, busy, exp_fb, exp_busy); end
      if (ram_feedback === 1'b1) pulses++;
    end
    sample = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL layer_pulses: got %0d want 1", pulses); end
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      tick();
      want = 16 * (a / 4) + (a % 4);
      checks++; if (rd_data !== 16'(want) || rd_data !== exp_rd) begin errors++; $display("FAIL layer_ram[%0d]: got %0d want %0d", a, rd_data, want); end
    end
    rd_en = 1'b0;
    // Layer complete: further samples are ignored.
    sample = 1'b1; foreach (ofm[i]) ofm[i] = 16'hFFFF;
    tick();
    sample = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (busy !== 1'b0 || ram_feedback !== 1'b0) begin errors++; $display("FAIL done_ignore cyc%0d: got busy%b fb%b want 0 0", i, busy, ram_feedback); end
      tick();
    end
    rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL done_no_write: got %h want 0", rd_data); end
  endtask

  task automatic test_read();
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    checks++; if (rd_data !== 16'd17) begin errors++; $display("FAIL read_addr5: got %0d want 17", rd_data); end
    rd_en = 1'b0; rd_addr = 4'd9;
    tick(); tick();
    checks++; if (rd_data !== 16'd17) begin errors++; $display("FAIL read_hold: got %0d want 17", rd_data); end
    rd2_en = 1'b1; rd2_addr = 5'd5;
    tick();
    checks++; if (rd2_data !== 16'd17 || rd2_data !== exp_rd2) begin errors++; $display("FAIL read2_addr5: got %0d want 17", rd2_data); end
    rd2_addr = 5'd20;
    tick();
    rd2_en = 1'b0;
    checks++; if (rd2_data !== 16'd0) begin errors++; $display("FAIL read2_oob: got %0d want 0", rd2_data); end
  endtask

  task automatic test_collision();
    assert_reset(); release_reset();
    collect_en = 1'b1; rand_ofm(); sample = 1'b1;
    tick();
    sample = 1'b0; rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    checks++; if (rd_data !== 16'd0 || rd_data !== exp_rd) begin errors++; $display("FAIL collision_old: got %h want %h", rd_data, exp_rd); end
    tick();
    checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL collision_new: got %h want %h", rd_data, exp_rd); end
    rd_en = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_drain();
    logic [WIDTH-1:0] va [DSP_NO];
    logic [WIDTH-1:0] vc [DSP_NO];
    logic [WIDTH-1:0] old8;
    assert_reset(); release_reset();
    old8 = m_mem[8];
    collect_en = 1'b1; rand_ofm(); va = ofm; sample = 1'b1;
    rd_en = 1'b1; rd_addr = 4'd12;
    tick();
    rand_ofm();
    tick();
    sample = 1'b0; rd_en = 1'b0;
    tick();
    assert_reset();
    checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy%b ovf%b want 0 0", busy, overflow); end
    checks++; if (rd_data !== 16'd0 || ram_feedback !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got rd%h fb%b want 0 0", rd_data, ram_feedback); end
    release_reset();
    for (int c = 0; c < 3; c++) begin
      rd_en = 1'b1; rd_addr = 4'(4 * c);
      tick();
      checks++; if (rd_data !== ((c < 2) ? va[c] : old8)) begin errors++; $display("FAIL midrst_ram[%0d]: got %h want %h", 4 * c, rd_data, (c < 2) ? va[c] : old8); end
    end
    rd_en = 1'b0;
    rand_ofm(); vc = ofm; sample = 1'b1;
    tick();
    sample = 1'b0;
    repeat (5) tick();
    for (int c = 0; c < DSP_NO; c++) begin
      rd_en = 1'b1; rd_addr = 4'(4 * c);
      tick();
      checks++; if (rd_data !== vc[c]) begin errors++; $display("FAIL midrst_restart_ram[%0d]: got %h want %h", 4 * c, rd_data, vc[c]); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_random();
    int pulses;
    int extra;
    assert_reset(); release_reset();
    pulses = 0; extra = 0;
    for (int t = 0; t < 600 && extra < 8; t++) begin
      sample     = ($urandom_range(0, 2) == 0);
      collect_en = ($urandom_range(0, 3) != 0);
      rd_en      = $urandom_range(0, 1) == 1;
      rd_addr    = 4'($urandom);
      rand_ofm();
      tick();
      if (m_done) extra++;
      if (ram_feedback === 1'b1) pulses++;
      checks++; if (busy !== exp_busy || overflow !== exp_ovf || ram_feedback !== exp_fb) begin
        errors++; $display("FAIL random_flags t%0d: got busy%b ovf%b fb%b want %b %b %b", t, busy, overflow, ram_feedback, exp_busy, exp_ovf, exp_fb);
      end
      if (exp_rd_known) begin
        checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL random_rd t%0d: got %h want %h", t, rd_data, exp_rd); end
      end
    end
    sample = 1'b0; rd_en = 1'b0;
    checks++; if (!m_done) begin errors++; $display("FAIL random_timeout: layer not completed in 600 cycles"); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL random_pulses: got %0d want 1", pulses); end
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      tick();
      checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL random_ram[%0d]: got %h want %h", a, rd_data, exp_rd); end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_overflow();
    test_overflow_last_write();
    test_gating();
    test_full_layer();
    test_read();
    test_collision();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fire9_ofm_collector.md
FIRE9_OFM_COLLECTOR -- requirements
Module: fire9_ofm_collector

Interface
REQ-001 SHALL have parameter DSP_NO, default 368, number of parallel output channels per sample.
REQ-002 SHALL have parameter WIDTH, default 16, bits per feature-map word.
REQ-003 SHALL have parameter WOUT, default 8, output spatial dimension; one layer = WOUT**2 samples.
REQ-004 SHALL have parameter DEPTH, default DSP_NO*WOUT**2, RAM words; address width AW = $clog2(DEPTH).
REQ-005 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port collect_en  input  1  collector armed; samples are ignored while low.
REQ-008 SHALL have port sample  input  1  one-cycle pulse, ofm vector valid in the same cycle.
REQ-009 SHALL have port ofm  input  WIDTH x DSP_NO (unpacked array)  channel results of one pixel.
REQ-010 SHALL have port ram_feedback  output  1  one-cycle pulse when the whole layer is stored.
REQ-011 SHALL have port busy  output  1  high while in DRAIN.
REQ-012 SHALL have port overflow  output  1  sticky flag, a sample arrived while DRAIN was still in progress.
REQ-013 SHALL have port rd_en  input  1  read request.
REQ-014 SHALL have port rd_addr  input  AW  read address.
REQ-015 SHALL have port rd_data  output  WIDTH  read data, registered.

Function
REQ-016 SHALL implement FSM states IDLE, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE: when sample=1 and collect_en=1, SHALL latch all DSP_NO ofm words into a shadow register bank at that edge, set ch=0, and enter DRAIN next cycle.
REQ-018 DRAIN: SHALL write shadow[ch] to ram[ch*WOUT**2 + pix] once per cycle, with ch incrementing 0..DSP_NO-1; write burst takes exactly DSP_NO cycles.
REQ-019 Address arithmetic SHALL use a running base plus WOUT**2 stride accumulator, with no multiplier; all addresses fall in 0..DEPTH-1.
REQ-020 On the write with ch=DSP_NO-1: pix increments; if the new pix equals WOUT**2, next state is DONE, otherwise IDLE.
REQ-021 DONE: SHALL assert ram_feedback for exactly the first cycle in DONE, then hold DONE and ignore further samples until reset.
REQ-022 sample=1 while in DRAIN SHALL be dropped: shadow bank unchanged, overflow set to 1 and held until reset.
REQ-023 sample=1 coincident with the final DRAIN write (ch=DSP_NO-1) SHALL count as overflow, not as a capture.
REQ-024 sample with collect_en=0 SHALL be ignored in every state, with no flag raised.
REQ-025 Read port SHALL give rd_data = ram[rd_addr] one cycle after rd_en=1 and hold its value while rd_en=0; reads are legal in all states; a read and write to the same address in one cycle returns old data.
REQ-026 An rd_addr value >= DEPTH SHALL return 0.
REQ-027 busy SHALL equal (state==DRAIN), combinational from the state register.
REQ-028 RAM SHALL be a single write port and single read port inferred block RAM; RAM contents are not reset.

Reset
REQ-029 rst low SHALL asynchronously force state=IDLE, ch=0, pix=0, ram_feedback=0, overflow=0, rd_data=0.
REQ-030 Reset asserted during DRAIN SHALL abort the burst; words already written stay in RAM, and the next layer restarts at pix=0.
REQ-031 Shadow bank SHALL need no reset; it is only read after a capture.

Verification (bench params: DSP_NO=4, WIDTH=16, WOUT=2, so DEPTH=16)
REQ-032 Single capture: collect_en=1, sample with ofm={10,20,30,40} -> busy high for 4 cycles; ram[0]=10, ram[4]=20, ram[8]=30, ram[12]=40; state returns to IDLE with pix=1.
REQ-033 Full layer: 4 samples spaced 10 cycles apart, pixel p carries ofm[c]=16*c+p -> ram[4c+p]=16c+p for all c,p; ram_feedback is a single one-cycle pulse 1 cycle after the 4th burst ends.
REQ-034 Overflow: second sample 2 cycles after the first -> overflow=1 and stays 1; RAM holds only the first vector; pix=1.
REQ-035 Gating and DONE: sample with collect_en=0 -> no write, busy stays 0; a sample after DONE -> no write and no second ram_feedback pulse.
REQ-036 Read timing: rd_en=1, rd_addr=5 -> rd_data=ram[5] on the next cycle; rd_addr=20 -> rd_data=0.
REQ-037 Reset mid-DRAIN: rst low at ch=2 -> all outputs return to reset values at once; after release, the next sample writes ram[0], ram[4], ram[8], ram[12].
